// File: rtl/dot_acc_pkg.sv
// Shared types and defaults for the dot-product accumulator that follows
// the two-lane multiply-add pipeline.
package dot_acc_pkg;

    localparam int DATA_W    = 32;
    localparam int DEF_LAT   = 3;
    localparam int DEF_ACC_W = 40;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dot_accumulator_if.sv
// Job control, pipeline sample and result handshake of the dot accumulator.
// The producer/consumer side uses master; the accumulator uses slave.
interface dot_accumulator_if
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) ();

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              op_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              busy;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              overflow;

    modport master (
        output start, len, op_valid, in_data, out_ready,
        input  busy, out_valid, out_sum, overflow
    );

    modport slave (
        input  start, len, op_valid, in_data, out_ready,
        output busy, out_valid, out_sum, overflow
    );

endinterface

// File: rtl/valid_delay_line.sv
// LAT-stage valid shift register with asynchronous active-low clear; q is
// the input delayed by exactly LAT clock cycles.
module valid_delay_line #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [LAT-1:0] stage;

    // A one-stage line has no lower slice to shift, so it gets its own branch.
    if (LAT == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                stage <= d;
            end
        end
    end else begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                stage <= {stage[LAT-2:0], d};
            end
        end
    end

    assign q = stage[LAT-1];

endmodule

// File: rtl/dot_accumulator.sv
// Sums a programmed number of pipeline C samples into one dot product and
// hands it out on a valid/ready port with a sticky overflow flag.
module dot_accumulator
    import dot_acc_pkg::*;
#(
    parameter int LAT   = DEF_LAT,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    dot_accumulator_if.slave bus
);

    localparam int SUM_W = ACC_W + 1;

    state_t           state;
    state_t           state_next;
    logic             aligned_valid;
    logic             start_accept;
    logic             sample_take;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] last_idx;
    logic [ACC_W-1:0] acc;
    logic             overflow_reg;
    logic [SUM_W-1:0] sum_ext;

    valid_delay_line #(.LAT(LAT)) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.op_valid),
        .q     (aligned_valid)
    );

    assign start_accept = (state == IDLE) && bus.start;
    assign sample_take  = (state == ACCUM) && aligned_valid;
    assign last_idx     = len_reg - LEN_W'(1);
    // One extra bit catches the carry out of the accumulator.
    assign sum_ext      = {1'b0, acc} + SUM_W'(bus.in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (aligned_valid && (count == last_idx)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and overflow survive the return to IDLE until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg      <= '0;
            count        <= '0;
            acc          <= '0;
            overflow_reg <= 1'b0;
        end else if (start_accept) begin
            len_reg      <= bus.len;
            count        <= '0;
            acc          <= '0;
            overflow_reg <= 1'b0;
        end else if (sample_take) begin
            acc   <= sum_ext[ACC_W-1:0];
            count <= count + LEN_W'(1);
            if (sum_ext[ACC_W]) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench: two accumulators (ACC_W=40 and ACC_W=32, both LAT=3) driven
// in lockstep, checked against hand-computed sums and flags.
module tb_dot_accumulator;

    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;

    always #5 clk = ~clk;

    dot_accumulator_if #(.ACC_W(40), .LEN_W(16)) bus_a ();
    dot_accumulator_if #(.ACC_W(32), .LEN_W(16)) bus_b ();

    dot_accumulator #(.LAT(3), .ACC_W(40), .LEN_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dot_accumulator #(.LAT(3), .ACC_W(32), .LEN_W(16)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs on both DUTs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic s, input logic [15:0] l, input logic ov,
                                 input logic [31:0] d, input logic rdy);
        bus_a.start = s;  bus_a.len = l;  bus_a.op_valid = ov;  bus_a.in_data = d;  bus_a.out_ready = rdy;
        bus_b.start = s;  bus_b.len = l;  bus_b.op_valid = ov;  bus_b.in_data = d;  bus_b.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b0);
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.len = '0; bus_a.op_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.len = '0; bus_b.op_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_busy",      64'(bus_a.busy),      64'd0);
        checkOutput("reset_out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("reset_out_sum",   64'(bus_a.out_sum),   64'd0);
        checkOutput("reset_overflow",  64'(bus_a.overflow),  64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(3);

        // Basic job: three back-to-back samples, start pulse in DONE ignored
        applyStimulus(1'b1, 16'd3, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        checkOutput("basic_busy", 64'(bus_a.busy), 64'd1);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd10, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd20, 1'b0);
        checkOutput("basic_not_early", 64'(bus_a.out_valid), 64'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd30, 1'b0);
        checkOutput("basic_out_valid", 64'(bus_a.out_valid), 64'd1);
        checkOutput("basic_out_sum",   64'(bus_a.out_sum),   64'd60);
        checkOutput("basic_overflow",  64'(bus_a.overflow),  64'd0);
        applyStimulus(1'b1, 16'd7, 1'b0, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b0);
        checkOutput("basic_hold_valid", 64'(bus_a.out_valid), 64'd1);
        checkOutput("basic_hold_sum",   64'(bus_a.out_sum),   64'd60);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);
        checkOutput("basic_idle_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("basic_idle_busy",  64'(bus_a.busy),      64'd0);
        checkOutput("basic_idle_sum",   64'(bus_a.out_sum),   64'd60);

        // Gapped samples, carry past 32 bits, long back-pressure
        applyStimulus(1'b1, 16'd2, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd7, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        checkOutput("gap_not_done", 64'(bus_a.out_valid), 64'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        checkOutput("gap_sum_a",  64'(bus_a.out_sum),  64'h1_0000_0006);
        checkOutput("gap_ovf_a",  64'(bus_a.overflow), 64'd0);
        checkOutput("gap_sum_b",  64'(bus_b.out_sum),  64'd6);
        checkOutput("gap_ovf_b",  64'(bus_b.overflow), 64'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b0);
            checkOutput("gap_stall_valid", 64'(bus_a.out_valid), 64'd1);
            checkOutput("gap_stall_sum",   64'(bus_a.out_sum),   64'h1_0000_0006);
        end
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);
        checkOutput("gap_released",    64'(bus_a.out_valid), 64'd0);
        checkOutput("gap_ovf_b_stick", 64'(bus_b.overflow),  64'd1);

        // Zero-length job, ignored starts in DONE including the release cycle
        applyStimulus(1'b1, 16'd0, 1'b0, GARBAGE, 1'b0);
        checkOutput("zero_out_valid", 64'(bus_a.out_valid), 64'd1);
        checkOutput("zero_out_sum",   64'(bus_a.out_sum),   64'd0);
        checkOutput("zero_ovf_clr_b", 64'(bus_b.overflow),  64'd0);
        applyStimulus(1'b1, 16'd5, 1'b0, GARBAGE, 1'b0);
        checkOutput("zero_busy_held", 64'(bus_a.busy),      64'd1);
        checkOutput("zero_valid_held",64'(bus_a.out_valid), 64'd1);
        applyStimulus(1'b1, 16'd5, 1'b0, GARBAGE, 1'b1);
        checkOutput("zero_idle_busy", 64'(bus_a.busy),      64'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);
        checkOutput("zero_start_ignored", 64'(bus_a.busy),  64'd0);
        checkOutput("zero_ready_idle",    64'(bus_a.out_valid), 64'd0);

        // Overflow on the 32-bit instance, then cleared by the next job
        applyStimulus(1'b1, 16'd2, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd2, 1'b0);
        checkOutput("ovf_sum_b",   64'(bus_b.out_sum),   64'd1);
        checkOutput("ovf_flag_b",  64'(bus_b.overflow),  64'd1);
        checkOutput("ovf_sum_a",   64'(bus_a.out_sum),   64'h1_0000_0001);
        checkOutput("ovf_flag_a",  64'(bus_a.overflow),  64'd0);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);
        checkOutput("ovf_sticky_idle", 64'(bus_b.overflow), 64'd1);
        applyStimulus(1'b1, 16'd1, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd5, 1'b0);
        checkOutput("ovf_next_sum_b", 64'(bus_b.out_sum),  64'd5);
        checkOutput("ovf_next_flag_b",64'(bus_b.overflow), 64'd0);
        checkOutput("ovf_next_valid", 64'(bus_b.out_valid),64'd1);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);

        // Stray aligned valid while IDLE must not leak into the next job
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd99, 1'b0);
        applyStimulus(1'b1, 16'd1, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd4, 1'b0);
        checkOutput("stray_valid", 64'(bus_a.out_valid), 64'd1);
        checkOutput("stray_sum",   64'(bus_a.out_sum),   64'd4);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);

        // Reset in the middle of a three-sample job
        applyStimulus(1'b1, 16'd3, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b1, GARBAGE, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd1, 1'b0);
        checkOutput("rst_mid_busy_before", 64'(bus_a.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy",      64'(bus_a.busy),      64'd0);
        checkOutput("rst_mid_out_valid", 64'(bus_a.out_valid), 64'd0);
        checkOutput("rst_mid_out_sum",   64'(bus_a.out_sum),   64'd0);
        checkOutput("rst_mid_overflow",  64'(bus_a.overflow),  64'd0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(3);
        applyStimulus(1'b1, 16'd1, 1'b1, GARBAGE, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd8, 1'b0);
        checkOutput("rst_after_valid", 64'(bus_a.out_valid), 64'd1);
        checkOutput("rst_after_sum",   64'(bus_a.out_sum),   64'd8);
        applyStimulus(1'b0, 16'd0, 1'b0, GARBAGE, 1'b1);
        checkOutput("rst_after_idle",  64'(bus_a.busy),      64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
